// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
// Shared frontend sizing and scheduler state encoding for the issue stage.
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package riscv_pkg;

  // Lanes per decoded bundle
  localparam int FRONTEND_WIDTH = 2;
  // Architectural registers tracked by the scoreboard
  localparam int NB_ARCH_REGS   = 32;

  // Scheduler occupancy: nothing held, bundle held, stuck on an illegal head
  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    HOLD    = 2'd1,
    BLOCKED = 2'd2
  } sched_state_t;

endpackage

`default_nettype wire

// File: rtl/sched_scoreboard.sv
// ---------------------------------------------------------------------------
// sched_scoreboard
// Pending-write bit per architectural register. Set on issue (one port per
// lane), cleared by a single writeback, wiped by flush. Lookups are purely
// combinational on the registered vector.
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module sched_scoreboard
  import riscv_pkg::*;
#(
  parameter int FRONTEND_WIDTH = 2,
  parameter int NB_ARCH_REGS   = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [FRONTEND_WIDTH-1:0]      i_set_valid,
  input  logic [FRONTEND_WIDTH-1:0][4:0] i_set_idx,
  input  logic                           i_clr_valid,
  input  logic [4:0]                     i_clr_idx,
  input  logic                           i_flush,
  input  logic [FRONTEND_WIDTH-1:0][4:0] i_rs1_idx,
  input  logic [FRONTEND_WIDTH-1:0][4:0] i_rs2_idx,
  output logic [FRONTEND_WIDTH-1:0]      o_rs1_pend,
  output logic [FRONTEND_WIDTH-1:0]      o_rs2_pend
);

  logic [NB_ARCH_REGS-1:0] r_pending;
  logic [NB_ARCH_REGS-1:0] w_next;

  // Clear first, then set, so a same-cycle set and clear leaves the bit set
  always_comb begin
    w_next = r_pending;
    if (i_clr_valid) begin
      w_next[i_clr_idx] = 1'b0;
    end
    for (int i = 0; i < FRONTEND_WIDTH; i++) begin
      if (i_set_valid[i] && (i_set_idx[i] != 5'd0)) begin
        w_next[i_set_idx[i]] = 1'b1;
      end
    end
  end

  // Pending vector register; x0 can never become pending
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_pending <= '0;
    end else begin
      r_pending <= w_next;
    end
  end

  // Per-lane source lookups
  always_comb begin
    o_rs1_pend = '0;
    o_rs2_pend = '0;
    for (int i = 0; i < FRONTEND_WIDTH; i++) begin
      o_rs1_pend[i] = r_pending[i_rs1_idx[i]];
      o_rs2_pend[i] = r_pending[i_rs2_idx[i]];
    end
  end

endmodule

`default_nettype wire

// File: rtl/issue_sched.sv
// ---------------------------------------------------------------------------
// issue_sched
// Holds one decoded bundle and issues its lanes strictly in order, stalling
// on RAW hazards against a register scoreboard and blocking on an illegal
// head instruction until flush.
// Optional build macro: SCHED_WB_BYPASS_EN (a source released by a writeback
// in the same cycle is not treated as a hazard).
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module issue_sched #(
  parameter int FRONTEND_WIDTH = riscv_pkg::FRONTEND_WIDTH,
  parameter int NB_ARCH_REGS   = riscv_pkg::NB_ARCH_REGS
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [FRONTEND_WIDTH-1:0]      dec_valid_i,
  output logic                           dec_ready_o,
  input  logic [FRONTEND_WIDTH-1:0]      rd_v_i,
  input  logic [FRONTEND_WIDTH-1:0]      rs1_v_i,
  input  logic [FRONTEND_WIDTH-1:0]      rs2_v_i,
  input  logic [FRONTEND_WIDTH-1:0]      illegal_inst_i,
  input  logic [FRONTEND_WIDTH-1:0][4:0] rd_i,
  input  logic [FRONTEND_WIDTH-1:0][4:0] rs1_i,
  input  logic [FRONTEND_WIDTH-1:0][4:0] rs2_i,
  output logic [FRONTEND_WIDTH-1:0]      issue_valid_o,
  input  logic [FRONTEND_WIDTH-1:0]      issue_ready_i,
  input  logic                           wb_valid_i,
  input  logic [4:0]                     wb_rd_i,
  input  logic                           flush_i,
  output logic                           exc_o
);

  import riscv_pkg::*;

  sched_state_t                   r_state;
  logic [FRONTEND_WIDTH-1:0]      r_valid, r_issued, r_ill;
  logic [FRONTEND_WIDTH-1:0]      r_rd_v, r_rs1_v, r_rs2_v;
  logic [FRONTEND_WIDTH-1:0][4:0] r_rd, r_rs1, r_rs2;

  logic [FRONTEND_WIDTH-1:0] w_rs1_pend, w_rs2_pend, w_rs1_busy, w_rs2_busy;
  logic [FRONTEND_WIDTH-1:0] w_remaining, w_haz, w_issue_valid, w_fire, w_set_valid;
  logic                      w_prior_ok, w_all_done, w_found, w_head_ill;
  logic                      w_dec_ready, w_accept;

  sched_scoreboard #(
    .FRONTEND_WIDTH(FRONTEND_WIDTH),
    .NB_ARCH_REGS  (NB_ARCH_REGS)
  ) u_sb (
    .clk        (clk),
    .rst        (reset),
    .i_set_valid(w_set_valid),
    .i_set_idx  (r_rd),
    .i_clr_valid(wb_valid_i),
    .i_clr_idx  (wb_rd_i),
    .i_flush    (flush_i),
    .i_rs1_idx  (r_rs1),
    .i_rs2_idx  (r_rs2),
    .o_rs1_pend (w_rs1_pend),
    .o_rs2_pend (w_rs2_pend)
  );

  // Scoreboard busy view per source, optionally forgiving a same-cycle writeback
  always_comb begin
    w_rs1_busy = '0;
    w_rs2_busy = '0;
    for (int i = 0; i < FRONTEND_WIDTH; i++) begin
`ifdef SCHED_WB_BYPASS_EN
      w_rs1_busy[i] = w_rs1_pend[i] && !(wb_valid_i && (wb_rd_i == r_rs1[i]));
      w_rs2_busy[i] = w_rs2_pend[i] && !(wb_valid_i && (wb_rd_i == r_rs2[i]));
`else
      w_rs1_busy[i] = w_rs1_pend[i];
      w_rs2_busy[i] = w_rs2_pend[i];
`endif
    end
  end

  // In-order issue selection: a lane may go only once every lower lane is done
  always_comb begin
    w_remaining   = '0;
    w_haz         = '0;
    w_issue_valid = '0;
    w_fire        = '0;
    w_prior_ok    = 1'b1;
    w_all_done    = 1'b1;
    w_found       = 1'b0;
    w_head_ill    = 1'b0;
    for (int i = 0; i < FRONTEND_WIDTH; i++) begin
      w_remaining[i] = (r_state == HOLD) && r_valid[i] && !r_issued[i];
      w_haz[i] = (r_rs1_v[i] && w_rs1_busy[i]) || (r_rs2_v[i] && w_rs2_busy[i]);
      // x0 writers never create intra-bundle dependencies
      for (int j = 0; j < i; j++) begin
        if (w_fire[j] && r_rd_v[j] && (r_rd[j] != 5'd0)) begin
          if ((r_rs1_v[i] && (r_rs1[i] == r_rd[j])) ||
              (r_rs2_v[i] && (r_rs2[i] == r_rd[j]))) begin
            w_haz[i] = 1'b1;
          end
        end
      end
      w_issue_valid[i] = w_remaining[i] && w_prior_ok && !r_ill[i] && !w_haz[i] && !flush_i;
      w_fire[i]        = w_issue_valid[i] && issue_ready_i[i];
      if (w_remaining[i] && !w_fire[i]) begin
        w_prior_ok = 1'b0;
        w_all_done = 1'b0;
      end
      if (!w_found && w_remaining[i]) begin
        w_found    = 1'b1;
        w_head_ill = r_ill[i];
      end
    end
    w_set_valid = w_fire & r_rd_v;
    w_dec_ready = !flush_i && ((r_state == EMPTY) ||
                  ((r_state == HOLD) && w_all_done && !w_head_ill));
    w_accept    = w_dec_ready && (|dec_valid_i);
  end

  assign dec_ready_o   = w_dec_ready;
  assign issue_valid_o = w_issue_valid;
  assign exc_o         = (r_state == BLOCKED) || ((r_state == HOLD) && w_head_ill);

  // Scheduler FSM and held bundle; reset beats flush, flush beats handshakes
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= EMPTY;
      r_valid  <= '0;
      r_issued <= '0;
      r_ill    <= '0;
      r_rd_v   <= '0;
      r_rs1_v  <= '0;
      r_rs2_v  <= '0;
      r_rd     <= '0;
      r_rs1    <= '0;
      r_rs2    <= '0;
    end else if (flush_i) begin
      r_state  <= EMPTY;
      r_valid  <= '0;
      r_issued <= '0;
    end else if (w_accept) begin
      r_state  <= HOLD;
      r_valid  <= dec_valid_i;
      r_issued <= '0;
      r_ill    <= illegal_inst_i;
      r_rd_v   <= rd_v_i;
      r_rs1_v  <= rs1_v_i;
      r_rs2_v  <= rs2_v_i;
      r_rd     <= rd_i;
      r_rs1    <= rs1_i;
      r_rs2    <= rs2_i;
    end else begin
      case (r_state)
        HOLD: begin
          if (w_all_done) begin
            r_state  <= EMPTY;
            r_valid  <= '0;
            r_issued <= '0;
          end else begin
            r_issued <= r_issued | w_fire;
            if (w_head_ill) begin
              r_state <= BLOCKED;
            end
          end
        end
        EMPTY, BLOCKED: r_state <= r_state;
        default:        r_state <= EMPTY;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_issue_sched.sv
// ---------------------------------------------------------------------------
// tb_issue_sched
// Directed bench for issue_sched with an expected-issue queue checked against
// every observed lane handshake (lane and cycle).
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_issue_sched;

  logic            clk = 1'b0;
  logic            reset;
  logic [1:0]      dec_valid, rd_v, rs1_v, rs2_v, ill, issue_ready, issue_valid;
  logic [1:0][4:0] rd, rs1, rs2;
  logic            dec_ready, wb_valid, flush, exc;
  logic [4:0]      wb_rd;

  int              cyc = 0;
  int              n_pass = 0;
  int              n_total = 0;
  logic [31:0]     exp_q[$];

  issue_sched dut (
    .clk           (clk),
    .reset         (reset),
    .dec_valid_i   (dec_valid),
    .dec_ready_o   (dec_ready),
    .rd_v_i        (rd_v),
    .rs1_v_i       (rs1_v),
    .rs2_v_i       (rs2_v),
    .illegal_inst_i(ill),
    .rd_i          (rd),
    .rs1_i         (rs1),
    .rs2_i         (rs2),
    .issue_valid_o (issue_valid),
    .issue_ready_i (issue_ready),
    .wb_valid_i    (wb_valid),
    .wb_rd_i       (wb_rd),
    .flush_i       (flush),
    .exc_o         (exc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic push_exp(input int lane, input int c);
    exp_q.push_back({8'(lane), 24'(c)});
  endtask

  // Pop one expectation per observed lane handshake, lane 0 first
  task automatic collect();
    logic [31:0] e;
    for (int i = 0; i < 2; i++) begin
      if (issue_valid[i] === 1'b1 && issue_ready[i] === 1'b1) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
        check("issue_order", {8'(i), 24'(cyc)}, e);
      end
    end
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic advance();
    collect();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    dec_valid   = 2'b00;
    rd_v        = 2'b00;
    rs1_v       = 2'b00;
    rs2_v       = 2'b00;
    ill         = 2'b00;
    rd          = '0;
    rs1         = '0;
    rs2         = '0;
    issue_ready = 2'b11;
    wb_valid    = 1'b0;
    wb_rd       = 5'd0;
    flush       = 1'b0;
  endtask

  task automatic set_lane(input int l, input logic rdv, input logic [4:0] rdx,
                          input logic s1v, input logic [4:0] s1,
                          input logic s2v, input logic [4:0] s2, input logic il);
    rd_v[l]  = rdv;
    rd[l]    = rdx;
    rs1_v[l] = s1v;
    rs1[l]   = s1;
    rs2_v[l] = s2v;
    rs2[l]   = s2;
    ill[l]   = il;
  endtask

  task automatic do_flush();
    idle();
    flush = 1'b1;
    settle();
    advance();
    flush = 1'b0;
  endtask

  int c;

  initial begin
    idle();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    settle();
    check("rst_dec_ready", 32'(dec_ready), 32'h1);
    check("rst_issue_valid", 32'(issue_valid), 32'h0);
    check("rst_exc", 32'(exc), 32'h0);
    check("rst_pending", dut.u_sb.r_pending, 32'h0);
    advance();

    // Back-to-back independent bundles
    for (int k = 0; k < 4; k++) begin
      idle();
      dec_valid = 2'b11;
      set_lane(0, 1'b1, 5'(2*k+1), 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
      set_lane(1, 1'b1, 5'(2*k+2), 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
      push_exp(0, cyc + 1);
      push_exp(1, cyc + 1);
      settle();
      check("b2b_ready", 32'(dec_ready), 32'h1);
      advance();
    end
    idle();
    settle();
    check("b2b_drain_ready", 32'(dec_ready), 32'h1);
    check("b2b_drain_valid", 32'(issue_valid), 32'h3);
    advance();
    do_flush();
    settle();
    check("flush_pending", dut.u_sb.r_pending, 32'h0);
    advance();

    // RAW on x5 inside one bundle, released by writeback
    c = cyc;
    idle();
    dec_valid = 2'b11;
    set_lane(0, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    set_lane(1, 1'b0, 5'd0, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0);
    push_exp(0, c + 1);
    settle();
    advance();
    idle();
    settle();
    check("raw_c1_valid", 32'(issue_valid), 32'h1);
    check("raw_c1_ready", 32'(dec_ready), 32'h0);
    advance();
    settle();
    check("raw_stall_valid", 32'(issue_valid), 32'h0);
    check("raw_pending_x5", dut.u_sb.r_pending, 32'h20);
    advance();
    wb_valid = 1'b1;
    wb_rd    = 5'd5;
    settle();
`ifdef SCHED_WB_BYPASS_EN
    check("raw_wb_bypass_valid", 32'(issue_valid), 32'h2);
    push_exp(1, c + 3);
`else
    check("raw_wb_stall_valid", 32'(issue_valid), 32'h0);
`endif
    advance();
    idle();
`ifndef SCHED_WB_BYPASS_EN
    settle();
    check("raw_after_wb_valid", 32'(issue_valid), 32'h2);
    push_exp(1, c + 4);
    advance();
`endif
    settle();
    check("raw_end_pending", dut.u_sb.r_pending, 32'h0);
    check("raw_end_ready", 32'(dec_ready), 32'h1);
    advance();

    // Lane 0 backpressure holds the bundle; a waiting bundle goes in on release
    c = cyc;
    idle();
    dec_valid = 2'b11;
    set_lane(0, 1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    set_lane(1, 1'b1, 5'd4, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    settle();
    advance();
    set_lane(0, 1'b1, 5'd9, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    set_lane(1, 1'b1, 5'd10, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    issue_ready = 2'b10;
    for (int k = 0; k < 3; k++) begin
      settle();
      check("bp_valid", 32'(issue_valid), 32'h1);
      check("bp_ready", 32'(dec_ready), 32'h0);
      advance();
    end
    issue_ready = 2'b11;
    push_exp(0, c + 4);
    push_exp(1, c + 4);
    push_exp(0, c + 5);
    push_exp(1, c + 5);
    settle();
    check("bp_release_valid", 32'(issue_valid), 32'h3);
    check("bp_release_ready", 32'(dec_ready), 32'h1);
    advance();
    idle();
    settle();
    check("bp_next_valid", 32'(issue_valid), 32'h3);
    advance();
    do_flush();

    // Illegal head: exception until flush
    idle();
    dec_valid = 2'b11;
    set_lane(0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1);
    set_lane(1, 1'b1, 5'd11, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    settle();
    advance();
    idle();
    dec_valid = 2'b11;
    for (int k = 1; k <= 3; k++) begin
      settle();
      check("ill_exc", 32'(exc), 32'h1);
      check("ill_valid", 32'(issue_valid), 32'h0);
      check("ill_ready", 32'(dec_ready), 32'h0);
      advance();
    end
    flush = 1'b1;
    settle();
    check("ill_flush_ready", 32'(dec_ready), 32'h0);
    advance();
    idle();
    settle();
    check("ill_post_ready", 32'(dec_ready), 32'h1);
    check("ill_post_exc", 32'(exc), 32'h0);
    check("ill_post_state", 32'(dut.r_state), 32'(riscv_pkg::EMPTY));
    advance();

    // x0 writer and x0 readers: no stall, nothing pending
    c = cyc;
    idle();
    dec_valid = 2'b11;
    set_lane(0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    set_lane(1, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0);
    push_exp(0, c + 1);
    push_exp(1, c + 1);
    settle();
    advance();
    idle();
    settle();
    check("x0_valid", 32'(issue_valid), 32'h3);
    advance();
    settle();
    check("x0_pending", dut.u_sb.r_pending, 32'h0);
    advance();

    // Same-cycle set and clear of x6 keeps it pending; a later clear releases it
    c = cyc;
    idle();
    dec_valid = 2'b01;
    set_lane(0, 1'b1, 5'd6, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    push_exp(0, c + 1);
    settle();
    advance();
    idle();
    wb_valid = 1'b1;
    wb_rd    = 5'd6;
    settle();
    check("setclr_valid", 32'(issue_valid), 32'h1);
    advance();
    settle();
    check("setclr_pending", dut.u_sb.r_pending, 32'h40);
    advance();
    idle();
    settle();
    check("clr_pending", dut.u_sb.r_pending, 32'h0);
    advance();

    // Lane invalid at accept is never issued nor recorded
    c = cyc;
    idle();
    dec_valid = 2'b10;
    set_lane(0, 1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    set_lane(1, 1'b0, 5'd0, 1'b1, 5'd7, 1'b0, 5'd0, 1'b0);
    push_exp(1, c + 1);
    settle();
    advance();
    idle();
    settle();
    check("invlane_valid", 32'(issue_valid), 32'h2);
    advance();
    settle();
    check("invlane_pending", dut.u_sb.r_pending, 32'h0);
    advance();

    // Reset while holding a stalled bundle with x3 and x7 pending
    c = cyc;
    idle();
    dec_valid = 2'b11;
    set_lane(0, 1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    set_lane(1, 1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    push_exp(0, c + 1);
    push_exp(1, c + 1);
    settle();
    advance();
    idle();
    dec_valid = 2'b01;
    set_lane(0, 1'b0, 5'd0, 1'b1, 5'd3, 1'b0, 5'd0, 1'b0);
    settle();
    check("rstH_accept_ready", 32'(dec_ready), 32'h1);
    advance();
    idle();
    issue_ready = 2'b00;
    flush       = 1'b1;
    reset       = 1'b1;
    settle();
    check("rstH_pending", dut.u_sb.r_pending, 32'h88);
    advance();
    reset = 1'b0;
    idle();
    settle();
    check("rstH_state", 32'(dut.r_state), 32'(riscv_pkg::EMPTY));
    check("rstH_pending_clr", dut.u_sb.r_pending, 32'h0);
    check("rstH_ready", 32'(dec_ready), 32'h1);
    check("rstH_valid", 32'(issue_valid), 32'h0);
    check("rstH_exc", 32'(exc), 32'h0);
    advance();

    check("exp_q_drained", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/issue_sched.md
ISSUE_SCHED -- requirements
Module: issue_sched

Interface
REQ-001 SHALL take parameter FRONTEND_WIDTH, default 2 from riscv package: lanes per decoded bundle.
REQ-002 SHALL take parameter NB_ARCH_REGS, default 32: architectural register count, one scoreboard bit each.
REQ-003 SHALL have ports clk, input, 1: the single clock.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port dec_valid_i, input, FRONTEND_WIDTH: per-lane bundle valid from decode.
REQ-006 SHALL have port dec_ready_o, output, 1: scheduler accepts the bundle this cycle.
REQ-007 SHALL have ports rd_v_i, rs1_v_i, rs2_v_i, illegal_inst_i, input, FRONTEND_WIDTH: decoded per-lane flags.
REQ-008 SHALL have ports rd_i, rs1_i, rs2_i, input, FRONTEND_WIDTH x 5: decoded register indices.
REQ-009 SHALL have port issue_valid_o, output, FRONTEND_WIDTH: lane issuable this cycle.
REQ-010 SHALL have port issue_ready_i, input, FRONTEND_WIDTH: backend accepts the lane.
REQ-011 SHALL have ports wb_valid_i (1) and wb_rd_i (5), inputs: one writeback releasing a register.
REQ-012 SHALL have port flush_i, input, 1: discard the held bundle and clear the scoreboard.
REQ-013 SHALL have port exc_o, output, 1: an illegal instruction is at the head of the held bundle.

Function
REQ-014 SHALL register one bundle: accepted when dec_valid_i has any bit set and dec_ready_o is high; visible on issue_valid_o the next cycle at the earliest.
REQ-015 SHALL run FSM states EMPTY, HOLD and BLOCKED.
- EMPTY->HOLD on accept.
- HOLD->EMPTY when all valid lanes are issued and there is no new accept.
- HOLD->HOLD on a new accept in the same cycle.
- HOLD->BLOCKED when the lowest un-issued lane has illegal_inst set.
REQ-016 SHALL assert issue_valid_o[i] only when all of the following hold:
- lane i is held and not yet issued;
- every lower valid lane is issued or issuing this cycle;
- lane i is not illegal;
- no RAW hazard exists (REQ-017).
REQ-017 SHALL flag a RAW hazard when rs1_v/rs2_v is set and:
- the source index is pending in the scoreboard and non-zero, or
- it equals the rd of a lower lane issuing in the same cycle.
REQ-018 SHALL count a lane as issued when issue_valid_o[i] and issue_ready_i[i] are both high.
- SHALL keep an issued-mask so a partially issued bundle re-presents only the remaining lanes (in-order, no lane skipping).
REQ-019 SHALL set pending[rd] on issue when rd_v is set and rd is non-zero; register 0 is never pending.
REQ-020 SHALL clear pending[wb_rd_i] on wb_valid_i; a same-cycle set and clear of one index SHALL leave it set.
REQ-021 SHALL drive dec_ready_o = (state EMPTY) or (HOLD and every remaining valid lane issues this cycle); it SHALL be forced low in BLOCKED and during flush_i.
REQ-022 SHALL assert exc_o combinationally in BLOCKED and hold it until flush_i.
REQ-023 SHALL, on flush_i, go to EMPTY the next cycle, clear the issued-mask and scoreboard, and ignore dec_valid_i, issue handshakes and writeback that cycle.
REQ-024 SHALL give no issue_valid_o to lanes whose dec_valid bit was low at accept.

Reset
REQ-025 SHALL, with reset high at a clk edge, enter EMPTY and clear the bundle, issued-mask and scoreboard.
- SHALL hold issue_valid_o=0, exc_o=0 and dec_ready_o=1 from the first cycle after reset.
REQ-026 Reset SHALL take priority over flush_i and all handshakes.

Configuration
REQ-027 With SCHED_WB_BYPASS_EN defined, a source whose pending bit is cleared by wb_valid_i in the same cycle SHALL NOT count as a hazard.
- Without the macro, that lane SHALL stall one extra cycle.

Structure
REQ-028 FRONTEND_WIDTH, NB_ARCH_REGS and enum sched_state_t {EMPTY, HOLD, BLOCKED} SHALL live in the riscv package.
REQ-029 The scoreboard SHALL be a sub-module sched_scoreboard: NB_ARCH_REGS-bit pending vector with FRONTEND_WIDTH set ports, one clear port, a flush, and combinational lookup.

Verification
REQ-030 Lanes (rd=x5), (rs1=x5), both ready -> cycle 1: lane0 only issues; lane1 issues after wb_rd_i=5 (same cycle with bypass, next cycle without).
REQ-031 Lane0 issue_ready_i=0 for 3 cycles -> lane1 issue_valid_o stays 0, dec_ready_o stays 0, bundle held.
REQ-032 Lane0 illegal_inst=1 -> exc_o=1 in cycle 1, no issue_valid_o; flush_i at cycle 4 -> EMPTY and dec_ready_o=1 at cycle 5.
REQ-033 Issue writing rd=x0 then a reader of rs1=x0 -> no stall, pending vector stays 0.
REQ-034 Back-to-back independent bundles with all ready -> one bundle accepted and fully issued every cycle, dec_ready_o constantly 1.
REQ-035 reset asserted while in HOLD with pending={x3,x7} -> next cycle EMPTY, scoreboard 0, all outputs at reset values.
